// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - round-robin intersection phase sequencer with all-red clearance and green watchdog
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high
//   phase_done   end-of-phase level from the light counter; its rising edge ends GREEN
//   veh_req      per-approach vehicle demand (level)
//   ped_req      per-approach pedestrian demand (pulse or level)
//   grant        one-hot active approach, zero during clearance
//   phase_start  one-cycle pulse as a new grant begins
//   all_red      high while no approach is granted
//   ped_walk     walk indication for the granted approach
//   cur_idx      index of the last/current granted approach
//   fault        sticky watchdog flag
module phase_sequencer #(
  parameter int N_APPR     = 4,
  parameter int ALLRED_CYC = 3,
  parameter int MAX_GREEN  = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      phase_done,
  input  logic [N_APPR-1:0]         veh_req,
  input  logic [N_APPR-1:0]         ped_req,
  output logic [N_APPR-1:0]         grant,
  output logic                      phase_start,
  output logic                      all_red,
  output logic [N_APPR-1:0]         ped_walk,
  output logic [$clog2(N_APPR)-1:0] cur_idx,
  output logic                      fault
);

  localparam int IW   = $clog2(N_APPR);
  // One timer serves both the clearance and the watchdog; it only ever
  // counts up to (limit-1) of the state it is in, so it never wraps.
  localparam int TMAX = (ALLRED_CYC > MAX_GREEN) ? ALLRED_CYC : MAX_GREEN;
  localparam int TW   = $clog2(TMAX);

  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] GREEN_LAST  = TW'(MAX_GREEN - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(N_APPR - 1);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_ALL_RED = 2'd1,
    S_GRANT   = 2'd2,
    S_GREEN   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [N_APPR-1:0] veh_pend, ped_pend;
  logic [N_APPR-1:0] veh_pend_nxt, ped_pend_nxt;
  logic              done_q;
  logic              done_ev;

  logic [N_APPR-1:0] grant_nxt, ped_walk_nxt, clr_mask;
  logic              phase_start_nxt, all_red_nxt, fault_nxt;
  logic [IW-1:0]     cur_idx_nxt;

  logic [N_APPR-1:0] pend;
  logic              sel_found;
  logic [IW-1:0]     sel_idx;

  assign done_ev = phase_done & ~done_q;
  assign pend    = veh_pend | ped_pend;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= N_APPR) s = s - N_APPR;
    return IW'(s);
  endfunction

  // Round-robin pick: cur_idx+1 first, cur_idx itself last. With no demand
  // the first grant after reset goes to approach 0; later ones rest in place.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = cur_idx;
    for (int j = 1; j <= N_APPR; j++) begin
      if (!sel_found && pend[wrap_add(cur_idx, j)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(cur_idx, j);
      end
    end
    if (!sel_found) begin
      sel_idx = (state == S_INIT) ? wrap_add(cur_idx, 1) : cur_idx;
    end
  end

  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    grant_nxt       = grant;
    phase_start_nxt = 1'b0;
    all_red_nxt     = all_red;
    ped_walk_nxt    = ped_walk;
    cur_idx_nxt     = cur_idx;
    fault_nxt       = fault;
    clr_mask        = '0;
    case (state)
      S_INIT, S_ALL_RED: begin
        if (timer == ALLRED_LAST) begin
          // Outputs are registered on entry to GRANT so they are valid in it.
          state_nxt       = S_GRANT;
          timer_nxt       = '0;
          grant_nxt       = N_APPR'(1) << sel_idx;
          ped_walk_nxt    = ped_pend[sel_idx] ? (N_APPR'(1) << sel_idx) : '0;
          cur_idx_nxt     = sel_idx;
          phase_start_nxt = 1'b1;
          all_red_nxt     = 1'b0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_GRANT: begin
        state_nxt = S_GREEN;
        timer_nxt = '0;
        clr_mask  = grant;
      end
      S_GREEN: begin
        if (done_ev || timer == GREEN_LAST) begin
          // done_ev has priority: a real end-of-phase never raises fault.
          if (!done_ev) fault_nxt = 1'b1;
          state_nxt    = S_ALL_RED;
          timer_nxt    = '0;
          grant_nxt    = '0;
          ped_walk_nxt = '0;
          all_red_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: begin
        state_nxt = S_ALL_RED;
        timer_nxt = '0;
      end
    endcase
  end

  // Set wins over clear, so demand still present while granted stays pending.
  assign veh_pend_nxt = (veh_pend & ~clr_mask) | veh_req;
  assign ped_pend_nxt = (ped_pend & ~clr_mask) | ped_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_INIT;
      timer       <= '0;
      veh_pend    <= '0;
      ped_pend    <= '0;
      done_q      <= 1'b0;
      grant       <= '0;
      phase_start <= 1'b0;
      all_red     <= 1'b1;
      ped_walk    <= '0;
      cur_idx     <= LAST_IDX;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      veh_pend    <= veh_pend_nxt;
      ped_pend    <= ped_pend_nxt;
      done_q      <= phase_done;
      grant       <= grant_nxt;
      phase_start <= phase_start_nxt;
      all_red     <= all_red_nxt;
      ped_walk    <= ped_walk_nxt;
      cur_idx     <= cur_idx_nxt;
      fault       <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench for phase_sequencer
module tb_phase_sequencer;

  localparam int N  = 4;
  localparam int AR = 3;
  localparam int MG = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         phase_done = 1'b0;
  logic [N-1:0] veh_req = '0;
  logic [N-1:0] ped_req = '0;
  logic [N-1:0] grant;
  logic         phase_start;
  logic         all_red;
  logic [N-1:0] ped_walk;
  logic [1:0]   cur_idx;
  logic         fault;

  phase_sequencer #(.N_APPR(N), .ALLRED_CYC(AR), .MAX_GREEN(MG)) dut (
    .clk(clk), .reset(reset), .phase_done(phase_done),
    .veh_req(veh_req), .ped_req(ped_req),
    .grant(grant), .phase_start(phase_start), .all_red(all_red),
    .ped_walk(ped_walk), .cur_idx(cur_idx), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the intersection as a sequence of segments
  // (0 = clearance, 1 = launch cycle, 2 = green) with an age counter.
  int m_seg, m_age, m_cur, m_first;
  int m_vp[N];
  int m_pp[N];
  int m_grant, m_walk, m_start, m_allred, m_fault, m_prev_done;

  task automatic model_reset();
    m_seg = 0; m_age = 0; m_cur = N - 1; m_first = 1;
    for (int i = 0; i < N; i++) begin m_vp[i] = 0; m_pp[i] = 0; end
    m_grant = 0; m_walk = 0; m_start = 0; m_allred = 1; m_fault = 0; m_prev_done = 0;
  endtask

  function automatic int pick();
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (m_cur + off) % N;
      if (m_vp[c] != 0 || m_pp[c] != 0) return c;
    end
    return (m_first != 0) ? (m_cur + 1) % N : m_cur;
  endfunction

  task automatic model_leave();
    m_seg = 0; m_age = 0; m_grant = 0; m_walk = 0; m_allred = 1;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] p, input logic d);
    int ev, launched, lidx, k;
    ev = (d && m_prev_done == 0) ? 1 : 0;
    launched = (m_seg == 1) ? 1 : 0;
    lidx = m_cur;
    m_start = 0;
    if (m_seg == 0) begin
      if (m_age == AR - 1) begin
        k = pick();
        m_grant = 1 << k;
        m_walk = (m_pp[k] != 0) ? (1 << k) : 0;
        m_cur = k; m_first = 0; m_allred = 0; m_start = 1;
        m_seg = 1; m_age = 0;
      end else m_age++;
    end else if (m_seg == 1) begin
      m_seg = 2; m_age = 0;
    end else begin
      if (ev != 0) model_leave();
      else if (m_age == MG - 1) begin m_fault = 1; model_leave(); end
      else m_age++;
    end
    if (launched != 0) begin m_vp[lidx] = 0; m_pp[lidx] = 0; end
    for (int i = 0; i < N; i++) begin
      if (v[i]) m_vp[i] = 1;
      if (p[i]) m_pp[i] = 1;
    end
    m_prev_done = d ? 1 : 0;
  endtask

  task automatic check_model();
    chk("model_grant", grant, m_grant);
    chk("model_start", phase_start, m_start);
    chk("model_allred", all_red, m_allred);
    chk("model_walk", ped_walk, m_walk);
    chk("model_idx", cur_idx, m_cur);
    chk("model_fault", fault, m_fault);
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] p, input logic d);
    veh_req = v; ped_req = p; phase_done = d;
    @(posedge clk);
    #1;
    model_step(v, p, d);
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_start"}, phase_start, 0);
    chk({tag, "_allred"}, all_red, 1);
    chk({tag, "_walk"}, ped_walk, 0);
    chk({tag, "_idx"}, cur_idx, N - 1);
    chk({tag, "_fault"}, fault, 0);
  endtask

  typedef struct {
    logic [N-1:0] veh;
    logic [N-1:0] ped;
    logic         done;
    logic [N-1:0] grant;
    logic         start;
    logic         allred;
    logic [N-1:0] walk;
    logic [1:0]   idx;
  } vec_t;

  vec_t tbl[27];

  initial begin
    // veh ped done | grant start allred walk idx
    tbl[0]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd3};
    tbl[1]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd3};
    tbl[2]  = '{4'h0, 4'h0, 1'b0, 4'h1, 1'b1, 1'b0, 4'h0, 2'd0};
    tbl[3]  = '{4'hA, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[4]  = '{4'h0, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[5]  = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 2'd0};
    tbl[6]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd0};
    tbl[7]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd0};
    tbl[8]  = '{4'h0, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 4'h0, 2'd1};
    tbl[9]  = '{4'h0, 4'h4, 1'b0, 4'h2, 1'b0, 1'b0, 4'h0, 2'd1};
    tbl[10] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 2'd1};
    tbl[11] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd1};
    tbl[12] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd1};
    tbl[13] = '{4'h0, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0, 4'h4, 2'd2};
    tbl[14] = '{4'h0, 4'h0, 1'b0, 4'h4, 1'b0, 1'b0, 4'h4, 2'd2};
    tbl[15] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 2'd2};
    tbl[16] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 2'd2};
    tbl[17] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 2'd2};
    tbl[18] = '{4'h0, 4'h0, 1'b1, 4'h8, 1'b1, 1'b0, 4'h0, 2'd3};
    tbl[19] = '{4'h0, 4'h0, 1'b1, 4'h8, 1'b0, 1'b0, 4'h0, 2'd3};
    tbl[20] = '{4'h0, 4'h0, 1'b0, 4'h8, 1'b0, 1'b0, 4'h0, 2'd3};
    tbl[21] = '{4'h0, 4'h0, 1'b0, 4'h8, 1'b0, 1'b0, 4'h0, 2'd3};
    tbl[22] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 2'd3};
    tbl[23] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd3};
    tbl[24] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd3};
    tbl[25] = '{4'h0, 4'h0, 1'b0, 4'h8, 1'b1, 1'b0, 4'h0, 2'd3};
    tbl[26] = '{4'h0, 4'h0, 1'b0, 4'h8, 1'b0, 1'b0, 4'h0, 2'd3};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    reset = 1'b0;

    // Directed walk through grant order, ped walk, held phase_done and rest.
    for (int r = 0; r < 27; r++) begin
      step(tbl[r].veh, tbl[r].ped, tbl[r].done);
      chk($sformatf("tbl%0d_grant", r), grant, tbl[r].grant);
      chk($sformatf("tbl%0d_start", r), phase_start, tbl[r].start);
      chk($sformatf("tbl%0d_allred", r), all_red, tbl[r].allred);
      chk($sformatf("tbl%0d_walk", r), ped_walk, tbl[r].walk);
      chk($sformatf("tbl%0d_idx", r), cur_idx, tbl[r].idx);
    end

    // phase_done rising exactly as the watchdog expires: no fault.
    repeat (MG - 1) step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    chk("race_fault", fault, 0);
    chk("race_allred", all_red, 1);
    repeat (3) step('0, '0, 1'b0);
    chk("race_rest_grant", grant, 4'h8);
    chk("race_rest_start", phase_start, 1);
    step('0, '0, 1'b0);

    // Watchdog expiry: after MG green cycles fault sets and clearance starts.
    repeat (MG - 1) begin
      step('0, '0, 1'b0);
      chk("wd_hold_fault", fault, 0);
      chk("wd_hold_grant", grant, 4'h8);
    end
    step('0, '0, 1'b0);
    chk("wd_fault", fault, 1);
    chk("wd_allred", all_red, 1);
    chk("wd_grant", grant, 0);
    repeat (3) step('0, '0, 1'b0);
    chk("wd_next_grant", grant, 4'h8);
    chk("wd_sticky", fault, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] v, p;
      logic d;
      v = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      p = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      d = ($urandom_range(0, 3) == 0);
      step(v, p, d);
    end

    // Reset mid-cycle, then demand on 2 wins the first grant.
    reset = 1'b1;
    #2;
    check_reset_vals("rst1");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(4'h4, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("rst1_grant2", grant, 4'h4);
    chk("rst1_idx2", cur_idx, 2);
    step(4'hA, '0, 1'b0);
    step('0, '0, 1'b0);

    // Reset while green on 2 with demand pending: demand is discarded.
    reset = 1'b1;
    #2;
    check_reset_vals("rst2");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("rst2_hold");
    reset = 1'b0;
    repeat (3) step('0, '0, 1'b0);
    chk("rst2_grant0", grant, 4'h1);
    chk("rst2_idx0", cur_idx, 0);
    step('0, '0, 1'b0);

    // Reset again, demand on 1 and 3 after release: lowest index first.
    reset = 1'b1;
    #2;
    check_reset_vals("rst3");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(4'hA, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("rst3_grant1", grant, 4'h2);
    chk("rst3_start", phase_start, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
